// File: rtl/alu_issue_stage.sv
// Operand-issue / writeback stage in front of the 4-bit ALU; owns the register file.
// Define FORWARD_EN to forward alu_result on RAW hazards instead of inserting a bubble.
module alu_issue_stage #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_bsel,
  input  logic [WIDTH-1:0]  in_imm,
  output logic [2:0]        alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [WIDTH-1:0]  wb_data,
  output logic              wb_zero,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [WIDTH-1:0]  r_rf [NREG];

  logic              r_ex_valid;
  logic              r_ex_we;
  logic [2:0]        r_ex_op;
  logic [WIDTH-1:0]  r_ex_a;
  logic [WIDTH-1:0]  r_ex_b;
  logic [ADDR_W-1:0] r_ex_rd;

  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [WIDTH-1:0]  r_wb_data;
  logic              r_wb_zero;

  logic              w_stall;
  logic              w_adv;
  logic              w_issue;
  logic              w_ex_wr;
  logic              w_haz_rs;
  logic              w_haz_rt;
  logic              w_bubble;
  logic [WIDTH-1:0]  w_rs_rf;
  logic [WIDTH-1:0]  w_rt_rf;
  logic [WIDTH-1:0]  w_rs_data;
  logic [WIDTH-1:0]  w_rt_data;
  logic [WIDTH-1:0]  w_b_data;

  assign w_stall  = r_wb_valid & ~wb_ready;
  assign w_adv    = r_ex_valid & ~w_stall;
  assign w_issue  = in_valid & in_ready;

  // EX entry that will write a real register when it advances
  assign w_ex_wr  = r_ex_valid & r_ex_we & (r_ex_rd != '0);
  assign w_haz_rs = w_ex_wr & (r_ex_rd == in_rs);
  assign w_haz_rt = w_ex_wr & ~in_bsel & (r_ex_rd == in_rt);

  assign w_rs_rf  = (in_rs == '0) ? '0 : r_rf[in_rs];
  assign w_rt_rf  = (in_rt == '0) ? '0 : r_rf[in_rt];

`ifdef FORWARD_EN
  assign w_bubble  = 1'b0;
  assign w_rs_data = w_haz_rs ? alu_result : w_rs_rf;
  assign w_rt_data = w_haz_rt ? alu_result : w_rt_rf;
`else
  assign w_bubble  = w_haz_rs | w_haz_rt;
  assign w_rs_data = w_rs_rf;
  assign w_rt_data = w_rt_rf;
`endif

  assign w_b_data = in_bsel ? in_imm : w_rt_data;

  assign in_ready = rst_n & ~(r_ex_valid & w_stall) & ~w_bubble;

  assign alu_op   = r_ex_op;
  assign alu_a    = r_ex_a;
  assign alu_b    = r_ex_b;

  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_zero  = r_wb_zero;

  assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_adv && w_ex_wr) begin
      r_rf[r_ex_rd] <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_we    <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_rd    <= '0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_we    <= in_we;
      r_ex_op    <= in_op;
      r_ex_a     <= w_rs_data;
      r_ex_b     <= w_b_data;
      r_ex_rd    <= in_rd;
    end else if (w_adv) begin
      r_ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_zero  <= 1'b0;
    end else if (w_adv) begin
      r_wb_valid <= 1'b1;
      r_wb_rd    <= r_ex_rd;
      r_wb_data  <= alu_result;
      r_wb_zero  <= alu_zero;
    end else if (wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + randomized bench for alu_issue_stage with an ALU stub and an
// architectural reference model (in-order register file + retirement queue).
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_rs;
  logic [2:0] in_rt;
  logic [2:0] in_rd;
  logic       in_we;
  logic       in_bsel;
  logic [3:0] in_imm;
  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_rd;
  logic [3:0] wb_data;
  logic       wb_zero;
  logic [2:0] dbg_addr;
  logic [3:0] dbg_data;

  alu_issue_stage #(.WIDTH(4), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_we(in_we), .in_bsel(in_bsel), .in_imm(in_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_zero(wb_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [2:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 4'd0);

  typedef struct {
    logic [2:0] rd;
    logic [3:0] d;
    logic       z;
  } exp_t;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] m_rf [8];
  exp_t       q [$];
  logic       p_stall;
  logic       p_valid;
  logic [2:0] p_rd;
  logic [3:0] p_data;
  logic       p_zero;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 4'd0;
    q.delete();
    p_stall = 1'b0;
  endtask

  task automatic tick(input logic v, input logic [2:0] op,
                      input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic we,
                      input logic bsel, input logic [3:0] imm,
                      input logic wr, output logic issued);
    exp_t       e;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    @(negedge clk);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_we = we; in_bsel = bsel; in_imm = imm; wb_ready = wr;
    #1;
    if (p_stall) begin
      check("stall_valid", wb_valid, p_valid);
      check("stall_rd", wb_rd, p_rd);
      check("stall_data", wb_data, p_data);
      check("stall_zero", wb_zero, p_zero);
    end
    p_stall = wb_valid & ~wb_ready;
    p_valid = wb_valid; p_rd = wb_rd; p_data = wb_data; p_zero = wb_zero;
    if (wb_valid && wb_ready) begin
      if (q.size() == 0) begin
        check("wb_spurious", wb_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("wb_rd", wb_rd, e.rd);
        check("wb_data", wb_data, e.d);
        check("wb_zero", wb_zero, e.z);
      end
    end
    issued = v & in_ready;
    if (issued) begin
      a = (rs == 3'd0) ? 4'd0 : m_rf[rs];
      b = bsel ? imm : ((rt == 3'd0) ? 4'd0 : m_rf[rt]);
      r = alu_f(op, a, b);
      if (we && rd != 3'd0) m_rf[rd] = r;
      q.push_back('{rd: rd, d: r, z: (r == 4'd0)});
    end
  endtask

  task automatic idle(input logic wr);
    logic iss;
    tick(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0, wr, iss);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd,
                       input logic we, input logic bsel,
                       input logic [3:0] imm, output int waits);
    logic iss;
    waits = 0;
    iss = 1'b0;
    for (int k = 0; k < 20 && !iss; k++) begin
      tick(1'b1, op, rs, rt, rd, we, bsel, imm, 1'b1, iss);
      if (!iss) waits++;
    end
    if (!iss) check("issue_timeout", iss, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (q.size() != 0 || wb_valid); k++) idle(1'b1);
    check("drain_q_empty", q.size(), 0);
    check("drain_wb_valid", wb_valid, 1'b0);
  endtask

  task automatic check_dbg(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check(tag, dbg_data, (i == 0) ? 4'd0 : m_rf[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] ops [5];
  int         w;
  logic       iss;

  initial begin
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    ops[3] = 3'b110; ops[4] = 3'b111;
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_we = 1'b0; in_bsel = 1'b0; in_imm = '0; wb_ready = 1'b1;
    dbg_addr = '0;
    model_reset();

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_alu_op", alu_op, 3'b000);
    check("rst_alu_a", alu_a, 4'd0);
    check("rst_alu_b", alu_b, 4'd0);
    check("rst_wb_rd", wb_rd, 3'd0);
    check("rst_wb_data", wb_data, 4'd0);
    check("rst_wb_zero", wb_zero, 1'b0);
    rst_n = 1'b1;
    idle(1'b1);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_wb_valid", wb_valid, 1'b0);
    check_dbg("dbg_after_reset");

    // 2: ADDI r1 = r0 + 5 and its latency
    issue(3'b010, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 4'd5, w);
    idle(1'b1);
    check("lat_edge_n", wb_valid, 1'b0);
    idle(1'b1);
    check("lat_edge_n1", wb_valid, 1'b1);
    dbg_addr = 3'd1; #1;
    check("dbg_r1", dbg_data, 4'd5);
    drain();

    // 3: back-to-back dependency r2 = r1 + r1
    issue(3'b010, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 4'd5, w);
    issue(3'b010, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 4'd0, w);
`ifdef FORWARD_EN
    check("raw_bubbles", w, 0);
`else
    check("raw_bubbles", w, 1);
`endif
    drain();
    check_dbg("dbg_raw");

    // 4: SUB r3 = r1 - r1 then dependent SLT r4 = r3 < r1
    issue(3'b110, 3'd1, 3'd1, 3'd3, 1'b1, 1'b0, 4'd0, w);
    issue(3'b111, 3'd3, 3'd1, 3'd4, 1'b1, 1'b0, 4'd0, w);
    drain();
    check_dbg("dbg_sub_slt");

    // 5: backpressure while streaming three ADDIs
    tick(1'b1, 3'b010, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 4'd1, 1'b0, iss);
    check("bp_issue1", iss, 1'b1);
    tick(1'b1, 3'b010, 3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 4'd2, 1'b0, iss);
    check("bp_issue2", iss, 1'b1);
    tick(1'b1, 3'b010, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 4'd3, 1'b0, iss);
    check("bp_full_ready", in_ready, 1'b0);
    tick(1'b1, 3'b010, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 4'd3, 1'b0, iss);
    check("bp_full_ready2", in_ready, 1'b0);
    issue(3'b010, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 4'd3, w);
    drain();
    check_dbg("dbg_bp");

    // 6: write to r0 dropped; reset with EX occupied
    issue(3'b010, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 4'd7, w);
    drain();
    dbg_addr = 3'd0; #1;
    check("dbg_r0", dbg_data, 4'd0);
    issue(3'b010, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 4'd9, w);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wb_valid", wb_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_alu_b", alu_b, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) idle(1'b1);
    check("post_rst_wb_valid", wb_valid, 1'b0);
    check_dbg("dbg_post_rst");

    // randomized stream with random backpressure
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 3) != 0, ops[$urandom_range(0, 4)],
           3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, iss);
    end
    drain();
    check_dbg("dbg_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue and writeback stage sitting directly upstream of the 4-bit ALU. It owns the 8-entry general register file.
- Accepts one instruction per cycle over a valid/ready handshake, reads source registers and drives the ALU's op/a/b inputs from an EX pipeline register.
- Captures the ALU's combinational result and zero flag into a WB register, then writes the result back to the register file.
- Presents the retired result to a downstream consumer through a second valid/ready handshake.

Parameters:
- WIDTH, 4, datapath width; must match the ALU operand width.
- ADDR_W, 3, register address width; the register file has 2**ADDR_W entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept an instruction.
- in_op  in  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- in_rs  in  ADDR_W  source A register.
- in_rt  in  ADDR_W  source B register.
- in_rd  in  ADDR_W  destination register.
- in_we  in  1  write result to rd.
- in_bsel  in  1  1 = operand B is in_imm, 0 = operand B is reg[rt].
- in_imm  in  WIDTH  immediate operand.
- alu_op  out  3  to ALU.
- alu_a  out  WIDTH  to ALU.
- alu_b  out  WIDTH  to ALU.
- alu_result  in  WIDTH  from ALU (combinational).
- alu_zero  in  1  from ALU.
- wb_valid  out  1  retired result available.
- wb_ready  in  1  consumer accepts the result.
- wb_rd  out  ADDR_W  destination of the retired instruction.
- wb_data  out  WIDTH  retired result.
- wb_zero  out  1  retired zero flag.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  WIDTH  combinational register read; reads 0 for address 0.

Behaviour:
Reset (rst_n low, asynchronous):
- All registers cleared, including ex_valid and wb_valid.
- alu_op=000, alu_a=0, alu_b=0, wb_rd=0, wb_data=0, wb_zero=0.
- in_ready=0 while rst_n is low.
- Reset mid-operation discards in-flight EX/WB contents with no register-file write.

Register file:
- Register 0 is hardwired to 0. Writes to register 0 are dropped.
- A write occurs only at the edge where a valid EX entry with ex_we=1 advances into WB.

Stall and handshakes:
- stall = wb_valid & ~wb_ready.
- in_ready = ~(ex_valid & stall) & ~hazard_bubble. hazard_bubble is always 0 when FORWARD_EN is defined.
- Issue edge (in_valid & in_ready):
  - ex_op <= in_op.
  - ex_a <= read(rs).
  - ex_b <= in_bsel ? in_imm : read(rt).
  - ex_rd, ex_we latched; ex_valid <= 1.
- On a non-issue edge where EX advances, ex_valid <= 0.
- alu_op/alu_a/alu_b are driven directly from the EX registers, so ALU inputs change one cycle after issue.

EX advance (ex_valid & ~stall, at the edge):
- wb_data <= alu_result, wb_zero <= alu_zero, wb_rd <= ex_rd, wb_valid <= 1.
- Register file written as described above.

WB handshake:
- wb_valid drops on the edge with wb_ready=1, unless EX advances on the same edge, in which case wb_valid stays 1 with the new data.
- wb_* outputs remain stable while stall=1.

Latency:
- Issue edge N puts the result on wb_* after edge N+1. The register file is updated at edge N+1.

RAW hazard:
- Applies when the EX entry has ex_valid & ex_we & ex_rd!=0 and ex_rd matches rs, or matches rt with in_bsel=0.
- Resolved per Optional Feature.

Arithmetic:
- Performed entirely in the ALU, mod 2**WIDTH; this stage does no arithmetic.

Simultaneous events:
- Issue and EX advance on the same edge is the normal streaming case; both take effect.

Optional Feature:
Macro FORWARD_EN.
- Defined: a read of a hazarding register returns alu_result instead of the register-file value. Dependent instructions issue back-to-back with no bubble.
- Undefined: on a hazard, hazard_bubble=1 for one cycle, so in_ready=0. The instruction issues on the next cycle and reads the freshly written register file.

Test Plan:
1. Assert reset, release, hold in_valid=0 -> in_ready=1, wb_valid=0, dbg_data=0 for all 8 addresses.
2. Issue ADD r1=r0+imm5 (op 010, bsel=1, imm=0101, we=1) with wb_ready=1 -> next cycle wb_data=0101, wb_zero=0, wb_rd=1; dbg(1)=0101.
3. Issue r1=5, then on the next cycle ADD r2=r1+r1 -> wb_data=1010. With FORWARD_EN: no in_ready drop. Without: exactly one in_ready=0 cycle, same final result.
4. With r1=5, SUB r3=r1-r1 (op 110), then SLT r4=r3<r1 (op 111) -> wb_data 0000/zero 1, then 0001/zero 0.
5. Hold wb_ready=0 for 3 cycles while streaming 3 ADDIs -> wb_* frozen, in_ready=0 once EX is full; after release, all 3 results retire in order with none lost or duplicated.
6. ADDI r0=imm 7 -> wb_data=0111 but dbg(0)=0. Pulse rst_n low while EX is valid -> wb_valid=0 and no register write.
